// File: rtl/os_ts_tracker_if.sv
// os_ts_tracker_if: ordered-set input block (16 lanes x 16 bytes) and tracker result bundle.
// The source drives the block through master; the tracker reads it through slave.
interface os_ts_tracker_if;
   logic          os_valid_in;
   logic [2047:0] os_in;
   logic [4:0]    num_lanes;
   logic [2:0]    gen;

   logic          os_valid;
   logic [2:0]    os_type;
   logic [3:0]    ts_count;
   logic          ts_ok;
   logic [7:0]    link_num;
   logic [7:0]    lane_num;
   logic [7:0]    n_fts;
   logic [7:0]    rate_id;
   logic [7:0]    train_ctrl;
   logic          link_pad;
   logic          lane_pad;
   logic          lane_err;

   modport master (
      output os_valid_in, os_in, num_lanes, gen,
      input  os_valid, os_type, ts_count, ts_ok, link_num, lane_num, n_fts, rate_id,
             train_ctrl, link_pad, lane_pad, lane_err
   );

   modport slave (
      input  os_valid_in, os_in, num_lanes, gen,
      output os_valid, os_type, ts_count, ts_ok, link_num, lane_num, n_fts, rate_id,
             train_ctrl, link_pad, lane_pad, lane_err
   );
endinterface

// File: rtl/os_ts_tracker.sv
// os_ts_tracker: two-stage ordered-set classifier with a consecutive identical TS1/TS2 counter.
// Define OS_LANE_ORDER_CHECK_EN to build the lane-number ordering check that drives lane_err.
module os_ts_tracker #(
   parameter int unsigned LANES = 16
) (
   input  logic           clk,
   input  logic           reset,
   os_ts_tracker_if.slave bus
);

   localparam logic [2:0] OsNone  = 3'd0;
   localparam logic [2:0] OsTs1   = 3'd1;
   localparam logic [2:0] OsTs2   = 3'd2;
   localparam logic [2:0] OsSkp   = 3'd3;
   localparam logic [2:0] OsEios  = 3'd4;
   localparam logic [2:0] OsEieos = 3'd5;
   localparam logic [2:0] OsMixed = 3'd6;

   function automatic logic [2:0] classify(input logic [127:0] lane, input logic gen3);
      logic ts1_tail;
      logic ts2_tail;
      ts1_tail = 1'b1;
      ts2_tail = 1'b1;
      for (int i = 6; i < 16; i++) begin
         if (lane[8*i +: 8] != 8'h4A) ts1_tail = 1'b0;
         if (lane[8*i +: 8] != 8'h45) ts2_tail = 1'b0;
      end
      classify = OsNone;
      if (gen3) begin
         if (lane[7:0] == 8'h1E)                classify = OsTs1;
         else if (lane[7:0] == 8'h2D)           classify = OsTs2;
         else if (lane[31:0] == 32'hAAAA_AAAA)  classify = OsSkp;
         else if (lane[31:0] == 32'h6666_6666)  classify = OsEios;
         else if (lane[15:0] == 16'hFF00)       classify = OsEieos;
      end else if (lane[7:0] == 8'hBC) begin
         if (ts1_tail)                          classify = OsTs1;
         else if (ts2_tail)                     classify = OsTs2;
         else if (lane[31:8] == 24'h1C1C1C)     classify = OsSkp;
         else if (lane[31:8] == 24'h7C7C7C)     classify = OsEios;
      end
   endfunction

   // ---------------- stage 1: per-lane classification ----------------
   logic [4:0]       lanes_eff;
   logic [15:0]      active;
   logic [15:0][2:0] cls;
   logic             link_all;
   logic             lane_all;
   logic             cfg_chg;

   logic             cfg_seen;
   logic [2:0]       gen_q;
   logic [4:0]       nl_q;

   logic             s1_valid;
   logic [15:0][2:0] s1_cls;
   logic [15:0]      s1_active;
   logic [39:0]      s1_bytes;
   logic             s1_link;
   logic             s1_lane;
   logic             s1_cfg_chg;

   always_comb begin
      case (bus.num_lanes)
         5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_eff = bus.num_lanes;
         default:                       lanes_eff = 5'd1;
      endcase
   end

   always_comb begin
      active   = '0;
      cls      = '0;
      link_all = 1'b1;
      lane_all = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k < int'(lanes_eff) && k < int'(LANES)) begin
            active[k] = 1'b1;
            cls[k]    = classify(bus.os_in[128*k +: 128], bus.gen >= 3'd3);
            if (bus.os_in[128*k+8 +: 8] != 8'hF7)  link_all = 1'b0;
            if (bus.os_in[128*k+16 +: 8] != 8'hF7) lane_all = 1'b0;
         end
      end
   end

   // A config change invalidates the running count before the new block reaches stage 2.
   assign cfg_chg = cfg_seen && ((bus.gen != gen_q) || (bus.num_lanes != nl_q));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_seen   <= 1'b0;
         gen_q      <= '0;
         nl_q       <= '0;
         s1_valid   <= 1'b0;
         s1_cls     <= '0;
         s1_active  <= '0;
         s1_bytes   <= '0;
         s1_link    <= 1'b0;
         s1_lane    <= 1'b0;
         s1_cfg_chg <= 1'b0;
      end else begin
         s1_valid <= bus.os_valid_in;
         if (bus.os_valid_in) begin
            cfg_seen   <= 1'b1;
            gen_q      <= bus.gen;
            nl_q       <= bus.num_lanes;
            s1_cls     <= cls;
            s1_active  <= active;
            s1_bytes   <= bus.os_in[47:8];
            s1_link    <= link_all;
            s1_lane    <= lane_all;
            s1_cfg_chg <= cfg_chg;
         end
      end
   end

   // ---------------- stage 2: resolve type, update counter ----------------
   logic [2:0]  res_type;
   logic        res_is_ts;
   logic        base_valid;
   logic [3:0]  base_cnt;
   logic [3:0]  cnt_d;
   logic        st_valid_d;
   logic [2:0]  st_type_d;
   logic [39:0] st_bytes_d;

   logic        os_valid_q;
   logic [2:0]  os_type_q;
   logic [3:0]  ts_count_q;
   logic        st_valid_q;
   logic [2:0]  st_type_q;
   logic [39:0] st_bytes_q;
   logic [39:0] out_bytes_q;
   logic        link_pad_q;
   logic        lane_pad_q;

   always_comb begin
      res_type = s1_cls[0];
      for (int k = 1; k < 16; k++) begin
         if (s1_active[k] && (s1_cls[k] != s1_cls[0])) res_type = OsMixed;
      end
   end

   assign res_is_ts = (res_type == OsTs1) || (res_type == OsTs2);

   always_comb begin
      base_valid = st_valid_q && !s1_cfg_chg;
      base_cnt   = s1_cfg_chg ? 4'd0 : ts_count_q;
      cnt_d      = base_cnt;
      st_valid_d = base_valid;
      st_type_d  = st_type_q;
      st_bytes_d = st_bytes_q;
      case (res_type)
         OsTs1, OsTs2: begin
            if (base_valid && (res_type == st_type_q) && (s1_bytes == st_bytes_q)) begin
               cnt_d = (base_cnt == 4'd15) ? 4'd15 : base_cnt + 4'd1;
            end else begin
               cnt_d      = 4'd1;
               st_valid_d = 1'b1;
               st_type_d  = res_type;
               st_bytes_d = s1_bytes;
            end
         end
         OsSkp: ;
         default: begin
            cnt_d      = 4'd0;
            st_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         os_valid_q  <= 1'b0;
         os_type_q   <= OsNone;
         ts_count_q  <= '0;
         st_valid_q  <= 1'b0;
         st_type_q   <= OsNone;
         st_bytes_q  <= '0;
         out_bytes_q <= '0;
         link_pad_q  <= 1'b0;
         lane_pad_q  <= 1'b0;
      end else begin
         os_valid_q <= s1_valid;
         if (s1_valid) begin
            os_type_q  <= res_type;
            ts_count_q <= cnt_d;
            st_valid_q <= st_valid_d;
            st_type_q  <= st_type_d;
            st_bytes_q <= st_bytes_d;
            link_pad_q <= s1_link;
            lane_pad_q <= s1_lane;
            if (res_is_ts) out_bytes_q <= s1_bytes;
         end
      end
   end

`ifdef OS_LANE_ORDER_CHECK_EN
   logic order_bad;
   logic s1_order_bad;
   logic lane_err_q;

   always_comb begin
      order_bad = 1'b0;
      for (int k = 1; k < 16; k++) begin
         if (active[k] && (bus.os_in[128*k+16 +: 8] != (bus.os_in[23:16] + 8'(k)))) begin
            order_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_order_bad <= 1'b0;
         lane_err_q   <= 1'b0;
      end else begin
         if (bus.os_valid_in) s1_order_bad <= order_bad;
         if (s1_valid)        lane_err_q   <= res_is_ts && !s1_lane && s1_order_bad;
      end
   end

   assign bus.lane_err = lane_err_q;
`else
   assign bus.lane_err = 1'b0;
`endif

   assign bus.os_valid   = os_valid_q;
   assign bus.os_type    = os_type_q;
   assign bus.ts_count   = ts_count_q;
   assign bus.ts_ok      = (ts_count_q >= 4'd8);
   assign bus.link_num   = out_bytes_q[7:0];
   assign bus.lane_num   = out_bytes_q[15:8];
   assign bus.n_fts      = out_bytes_q[23:16];
   assign bus.rate_id    = out_bytes_q[31:24];
   assign bus.train_ctrl = out_bytes_q[39:32];
   assign bus.link_pad   = link_pad_q;
   assign bus.lane_pad   = lane_pad_q;

endmodule
